// File: rtl/matrix_3x3_engine.sv
// 3x3 matrix multiply engine: loads A and B (18 words), computes C = A x B with one MAC,
// then streams C (9 words) out row-major over the ready/done handshake.
module matrix_3x3_engine #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_output,
  output logic [DATA_W-1:0] ram_input,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COMP  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]        r_ld_cnt;
  logic [3:0]        r_st_cnt;
  logic [1:0]        r_i;
  logic [1:0]        r_j;
  logic [1:0]        r_k;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ops [0:17];
  logic [DATA_W-1:0] r_c   [0:8];

  logic [4:0]          w_a_idx;
  logic [4:0]          w_b_idx;
  logic [3:0]          w_c_idx;
  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;
  logic [DATA_W-1:0]   w_prod_lo;
  logic [DATA_W-1:0]   w_acc_next;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD; else w_next = S_IDLE;
      S_LOAD:  if (r_ld_cnt == 5'd17) w_next = S_COMP; else w_next = S_LOAD;
      S_COMP:  if ((r_i == 2'd2) && (r_j == 2'd2) && (r_k == 2'd2)) w_next = S_STORE;
               else w_next = S_COMP;
      S_STORE: if (r_st_cnt == 4'd8) w_next = S_IDLE; else w_next = S_STORE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // MAC operand selection: A[i][k] * B[k][j], full-width product truncated
  always_comb begin
    w_a_idx = {3'b000, r_i} * 5'd3 + {3'b000, r_k};
    w_b_idx = 5'd9 + {3'b000, r_k} * 5'd3 + {3'b000, r_j};
    w_c_idx = {2'b00, r_i} * 4'd3 + {2'b00, r_j};
    if (SIGNED) begin
      w_a_ext = {{DATA_W{r_ops[w_a_idx][DATA_W-1]}}, r_ops[w_a_idx]};
      w_b_ext = {{DATA_W{r_ops[w_b_idx][DATA_W-1]}}, r_ops[w_b_idx]};
    end else begin
      w_a_ext = {{DATA_W{1'b0}}, r_ops[w_a_idx]};
      w_b_ext = {{DATA_W{1'b0}}, r_ops[w_b_idx]};
    end
    w_prod_lo = DATA_W'(w_a_ext * w_b_ext);
    if (r_k == 2'd0) w_acc_next = w_prod_lo;
    else             w_acc_next = r_acc + w_prod_lo;
  end

  // Operand capture, MAC accumulation, result buffer and counters
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_ld_cnt <= 5'd0;
      r_st_cnt <= 4'd0;
      r_i      <= 2'd0;
      r_j      <= 2'd0;
      r_k      <= 2'd0;
      r_acc    <= {DATA_W{1'b0}};
      for (int n = 0; n < 18; n++) r_ops[n] <= {DATA_W{1'b0}};
      for (int n = 0; n < 9; n++)  r_c[n]   <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ld_cnt <= 5'd0;
          r_st_cnt <= 4'd0;
          r_i      <= 2'd0;
          r_j      <= 2'd0;
          r_k      <= 2'd0;
        end
        S_LOAD: begin
          r_ops[r_ld_cnt] <= ram_output;
          r_ld_cnt        <= r_ld_cnt + 5'd1;
        end
        S_COMP: begin
          r_acc <= w_acc_next;
          if (r_k == 2'd2) begin
            r_c[w_c_idx] <= w_acc_next;
            r_k          <= 2'd0;
            if (r_j == 2'd2) begin
              r_j <= 2'd0;
              if (r_i == 2'd2) r_i <= 2'd0;
              else             r_i <= r_i + 2'd1;
            end else begin
              r_j <= r_j + 2'd1;
            end
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        S_STORE: r_st_cnt <= r_st_cnt + 4'd1;
        default: r_ld_cnt <= 5'd0;
      endcase
    end
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    ready = (r_state == S_LOAD);
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_STORE);
    we    = (r_state == S_STORE);
    if (r_state == S_STORE) ram_input = r_c[r_st_cnt];
    else                    ram_input = {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_matrix_3x3_engine.sv
// Self-checking bench for matrix_3x3_engine: directed and random jobs against a
// plain-arithmetic matrix product model, plus per-cycle handshake timing checks.
module tb_matrix_3x3_engine;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] ram_output;
  logic [31:0] ram_input;
  logic        ready, busy, done, we;

  int total = 0;
  int bad   = 0;

  logic [31:0] ops   [18];
  logic [31:0] exp_c [9];

  matrix_3x3_engine #(.DATA_W(32), .SIGNED(1'b1)) dut (
    .clk(clk), .clr(clr), .start(start), .ram_output(ram_output),
    .ram_input(ram_input), .ready(ready), .busy(busy), .done(done), .we(we)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // C = A x B modulo 2^32 (low 32 bits are the same for signed and unsigned)
  task automatic model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        logic [31:0] sum;
        sum = 32'd0;
        for (int k = 0; k < 3; k++) sum = sum + ops[3*r+k] * ops[9+3*k+c];
        exp_c[3*r+c] = sum;
      end
  endtask

  task automatic load_test1();
    for (int n = 0; n < 9; n++) begin
      ops[n]   = 32'(n + 1);
      ops[9+n] = 32'(9 - n);
    end
    exp_c = '{32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54, 32'd138, 32'd114, 32'd90};
  endtask

  task automatic check_idle(input string tag);
    check_val(tag, {60'd0, ready, busy, done, we}, 64'd0);
    check_val({tag, "_ri"}, {32'd0, ram_input}, 64'd0);
  endtask

  // Runs one job starting from an IDLE negedge; ends at the negedge of cycle 55
  task automatic run_job(input bit hold, input bit poke);
    int n, nd;
    logic [3:0] e;
    n = 0; nd = 0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (!hold) start = poke && (c == 5 || c == 48);
      e = {1'(c <= 18), 1'(c <= 54), 1'(c >= 46 && c <= 54), 1'(c >= 46 && c <= 54)};
      check_val($sformatf("hs_c%0d", c), {60'd0, ready, busy, done, we}, {60'd0, e});
      if (done) begin
        if (nd < 9) check_val($sformatf("c%0d", nd), {32'd0, ram_input}, {32'd0, exp_c[nd]});
        nd++;
      end
      if (ready && n < 18) begin
        ram_output = ops[n];
        n++;
      end else begin
        ram_output = $urandom;
      end
    end
    check_val("n_load", 64'(n), 64'd18);
    check_val("n_done", 64'(nd), 64'd9);
  endtask

  initial begin
    int nd;
    clr = 1'b0; start = 1'b0; ram_output = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    clr = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Basic product
    load_test1();
    run_job(1'b0, 1'b0);

    // Signed identity: -I x (1..9)
    for (int n = 0; n < 9; n++) begin
      ops[n]   = (n % 4 == 0) ? 32'hFFFF_FFFF : 32'd0;
      ops[9+n] = 32'(n + 1);
    end
    model();
    for (int n = 0; n < 9; n++) check_val("neg_model", {32'd0, exp_c[n]}, {32'd0, 32'd0 - 32'(n + 1)});
    run_job(1'b0, 1'b0);

    // Wrap-around
    for (int n = 0; n < 18; n++) ops[n] = 32'd0;
    ops[0] = 32'h0001_0000; ops[9] = 32'h0001_0000;
    model();
    run_job(1'b0, 1'b0);

    // Reset at compute cycle 10
    load_test1();
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) ram_output = ops[c-1];
      if (c == 28) clr = 1'b0;
    end
    @(negedge clk);
    clr = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) check_idle("abort");
      if (done || busy || ready) nd++;
      @(negedge clk);
    end
    check_val("abort_active", 64'(nd), 64'd0);
    run_job(1'b0, 1'b0);

    // Reset wins over simultaneous start
    clr = 1'b0; start = 1'b1;
    @(negedge clk);
    clr = 1'b1; start = 1'b0;
    @(negedge clk);
    check_idle("rst_wins");

    // Start pulses during LOAD and STORE are ignored
    load_test1();
    run_job(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle("no_queue");
    end

    // Back-to-back with start held
    for (int n = 0; n < 9; n++) begin
      ops[n]   = (n % 4 == 0) ? 32'd1 : 32'd0;
      ops[9+n] = 32'(n + 1);
    end
    model();
    run_job(1'b1, 1'b0);
    run_job(1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check_idle("b2b_end");

    // Random jobs
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < 18; n++)
        ops[n] = (t < 2) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      model();
      run_job(1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
